// File: rtl/acc_seq_ctrl.sv
// Accelerator job sequencer: streams a source block into the accelerator,
// waits for compute, then reads back result beats under consumer backpressure.
module acc_seq_ctrl #(
  parameter logic [31:0] ACC_BASE    = 32'h1000_0000,
  parameter int          LOAD_WORDS  = 25,
  parameter logic [31:0] RES_OFFSET  = 32'h0000_0064,
  parameter int          RD_BEATS    = 4,
  parameter int          WAIT_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] src_base,
  input  logic        abort,
  output logic        src_en,
  output logic [31:0] src_addr,
  input  logic [31:0] src_rdata,
  output logic        acc_en_w,
  output logic        acc_en_r,
  output logic [31:0] acc_addr,
  output logic [31:0] acc_wdata,
  input  logic [63:0] acc_rdata,
  output logic        res_valid,
  output logic [63:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        done
);

  localparam int CNT_MAX = (LOAD_WORDS > WAIT_CYCLES) ? LOAD_WORDS : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BEAT_W  = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
  localparam logic [31:0] RES_BASE = ACC_BASE + RES_OFFSET;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_RD_REQ, S_RD_CAP, S_OUT, S_DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BEAT_W-1:0]  beat, beat_n;
  logic [31:0]        base_q, base_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      beat     <= '0;
      base_q   <= '0;
      res_data <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      beat   <= beat_n;
      base_q <= base_n;
      if (state == S_RD_CAP) res_data <= acc_rdata;
    end
  end

  // Write data is the source read data passed straight through; the fetch of
  // word k and the write of word k-1 overlap in the same LOAD cycle.
  assign acc_wdata = src_rdata;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    beat_n    = beat;
    base_n    = base_q;
    src_en    = 1'b0;
    src_addr  = '0;
    acc_en_w  = 1'b0;
    acc_en_r  = 1'b0;
    acc_addr  = '0;
    res_valid = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          base_n  = src_base;
          cnt_n   = '0;
          beat_n  = '0;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt < CNT_W'(LOAD_WORDS)) begin
          src_en   = 1'b1;
          src_addr = base_q + (32'(cnt) << 2);
        end
        if (cnt != '0) begin
          acc_en_w = 1'b1;
          acc_addr = ACC_BASE + ((32'(cnt) - 32'd1) << 2);
        end
        if (cnt == CNT_W'(LOAD_WORDS)) begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = S_RD_REQ;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_RD_REQ: begin
        acc_en_r = 1'b1;
        acc_addr = RES_BASE + (32'(beat) << 3);
        state_n  = S_RD_CAP;
      end
      S_RD_CAP: state_n = S_OUT;
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (beat == BEAT_W'(RD_BEATS - 1)) begin
            state_n = S_DONE;
          end else begin
            beat_n  = beat + BEAT_W'(1);
            state_n = S_RD_REQ;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Abort wins over everything and silences the bus in the abort cycle too.
    if (abort && state != S_IDLE) begin
      state_n   = S_IDLE;
      src_en    = 1'b0;
      src_addr  = '0;
      acc_en_w  = 1'b0;
      acc_en_r  = 1'b0;
      acc_addr  = '0;
      res_valid = 1'b0;
      done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl: basic job timing, backpressure, abort,
// ignored starts, async reset mid-job and source address wrap.
module tb_acc_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_base = '0;
  logic        abort = 1'b0;
  logic        src_en;
  logic [31:0] src_addr;
  logic [31:0] src_rdata = '0;
  logic        acc_en_w, acc_en_r;
  logic [31:0] acc_addr, acc_wdata;
  logic [63:0] acc_rdata = '0;
  logic        res_valid;
  logic [63:0] res_data;
  logic        res_ready = 1'b1;
  logic        busy, done;

  acc_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_base(src_base), .abort(abort),
    .src_en(src_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .acc_en_w(acc_en_w), .acc_en_r(acc_en_r), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_rdata(acc_rdata), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tab_val(int i);
    case (i)
      16: return 32'd1;  17: return 32'd4;  18: return 32'd7;
      19: return 32'd2;  20: return 32'd5;  21: return 32'd8;
      22: return 32'd3;  23: return 32'd6;  24: return 32'd9;
      default: return 32'((i % 4) + 1);
    endcase
  endfunction

  function automatic logic [31:0] src_fn(logic [31:0] a);
    if (a >= 32'h100 && a < 32'h164) return tab_val(int'((a - 32'h100) >> 2));
    return {16'hDEAD, a[15:0]};
  endfunction

  // Memory models: one-cycle read latency on both sides.
  always @(posedge clk) begin
    if (src_en)   src_rdata <= src_fn(src_addr);
    if (acc_en_r) acc_rdata <= {32'hA5A5_A5A5, acc_addr};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], src_q[$];
  int          wr_cyc_q[$], rd_cyc_q[$];
  logic [63:0] beat_q[$];
  int          done_cnt = 0, done_cyc = 0, stab_err = 0, addr0_err = 0;
  logic        prev_v = 1'b0, prev_hs = 1'b0;
  logic [63:0] prev_d = '0;

  always @(negedge clk) begin
    if (acc_en_w) begin
      wr_addr_q.push_back(acc_addr); wr_data_q.push_back(acc_wdata); wr_cyc_q.push_back(cyc);
    end
    if (acc_en_r) begin
      rd_addr_q.push_back(acc_addr); rd_cyc_q.push_back(cyc);
    end
    if (src_en) src_q.push_back(src_addr);
    if (res_valid && res_ready) beat_q.push_back(res_data);
    if (done) begin
      done_cnt <= done_cnt + 1; done_cyc <= cyc;
    end
    if (prev_v && !prev_hs && res_valid && res_data !== prev_d) stab_err <= stab_err + 1;
    if (!acc_en_w && !acc_en_r && acc_addr !== 32'h0) addr0_err <= addr0_err + 1;
    prev_v  <= res_valid;
    prev_hs <= res_valid && res_ready;
    prev_d  <= res_data;
  end

  int checks = 0, failures = 0;
  int t0, wb, rb, bb, sb, db;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mark();
    wb = wr_addr_q.size(); rb = rd_addr_q.size(); bb = beat_q.size();
    sb = src_q.size(); db = done_cnt;
  endtask

  task automatic start_job(logic [31:0] base);
    mark();
    start = 1'b1; src_base = base; t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin step(); n++; end
    chk("idle_within_budget", busy, 1'b0);
    step(2);
  endtask

  // Contents of a complete job sourced from 0x100.
  task automatic verify_job(string tag);
    chk({tag, "_nwr"}, wr_addr_q.size() - wb, 25);
    if (wr_addr_q.size() - wb == 25)
      for (int i = 0; i < 25; i++) begin
        chk({tag, "_wa"}, wr_addr_q[wb+i], 32'h1000_0000 + 32'(4 * i));
        chk({tag, "_wd"}, wr_data_q[wb+i], tab_val(i));
      end
    chk({tag, "_nrd"}, rd_addr_q.size() - rb, 4);
    chk({tag, "_nbeat"}, beat_q.size() - bb, 4);
    if (rd_addr_q.size() - rb == 4 && beat_q.size() - bb == 4)
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_ra"}, rd_addr_q[rb+i], 32'h1000_0064 + 32'(8 * i));
        chk({tag, "_beat"}, beat_q[bb+i], {32'hA5A5_A5A5, 32'h1000_0064 + 32'(8 * i)});
      end
    chk({tag, "_done_cnt"}, done_cnt - db, 1);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_src_en", src_en, 0);     chk("rst_src_addr", src_addr, 0);
    chk("rst_acc_en_w", acc_en_w, 0); chk("rst_acc_en_r", acc_en_r, 0);
    chk("rst_acc_addr", acc_addr, 0); chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_res_data", res_data, 0);
    step(2); reset_n = 1'b1; step();

    // Basic job with timing
    start_job(32'h100);
    chk("basic_busy", busy, 1);
    wait_idle(200);
    verify_job("basic");
    if (wr_cyc_q.size() - wb == 25 && rd_cyc_q.size() - rb == 4) begin
      chk("basic_first_wr_cyc", wr_cyc_q[wb] - t0, 2);
      chk("basic_last_wr_cyc", wr_cyc_q[wb+24] - t0, 26);
      chk("basic_first_rd_cyc", rd_cyc_q[rb] - t0, 37);
      chk("basic_last_rd_cyc", rd_cyc_q[rb+3] - t0, 46);
    end
    chk("basic_done_cyc", done_cyc - t0, 49);
    chk("basic_src_first", src_q[sb], 32'h100);

    // Backpressure: beat 1 held 5 cycles in OUT
    start_job(32'h100);
    step(39); res_ready = 1'b0;          // cycle 40
    step(4); #3;                         // cycle 44, beat 1 waiting
    chk("bp_valid", res_valid, 1);
    chk("bp_data", res_data, {32'hA5A5_A5A5, 32'h1000_006C});
    step(3); res_ready = 1'b1;           // cycle 47
    wait_idle(200);
    verify_job("bp");
    if (rd_cyc_q.size() - rb == 4) chk("bp_rd2_cyc", rd_cyc_q[rb+2] - t0, 48);
    chk("bp_done_cyc", done_cyc - t0, 54);
    chk("bp_stable", stab_err, 0);

    // Abort while fetching word 7
    start_job(32'h100);
    step(7); abort = 1'b1;               // cycle 8
    step(); abort = 1'b0; #3;            // cycle 9
    chk("abort_busy", busy, 0);       chk("abort_src_en", src_en, 0);
    chk("abort_acc_en_w", acc_en_w, 0); chk("abort_acc_en_r", acc_en_r, 0);
    chk("abort_res_valid", res_valid, 0);
    step(3);
    chk("abort_no_done", done_cnt - db, 0);
    start_job(32'h100);
    wait_idle(200);
    verify_job("reload");

    // Starts during WAIT and DONE are ignored
    start_job(32'h100);
    step(29); start = 1'b1; src_base = 32'h200;   // cycle 30, WAIT
    step(); start = 1'b0;
    step(18); #3;                                 // cycle 49, DONE
    chk("bs_done_pulse", done, 1);
    start = 1'b1; src_base = 32'h200;
    step(); start = 1'b0; #3;
    chk("bs_idle_after_done", busy, 0);
    step(40);
    verify_job("bs");

    // Async reset while waiting in OUT
    res_ready = 1'b0;
    start_job(32'h100);
    step(40); #2;                        // cycle 41, mid-cycle
    reset_n = 1'b0; #1;
    chk("arst_res_valid", res_valid, 0);
    chk("arst_busy", busy, 0);
    step(3); reset_n = 1'b1; res_ready = 1'b1;
    step(2);
    chk("arst_no_done", done_cnt - db, 0);
    start_job(32'h100);
    wait_idle(200);
    verify_job("post_rst");

    // Abort in IDLE alongside start has no effect; source address wraps
    abort = 1'b1;
    start_job(32'hFFFF_FFF0);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1);
    wait_idle(200);
    chk("wrap_nsrc", src_q.size() - sb, 25);
    if (src_q.size() - sb == 25) begin
      chk("wrap_src3", src_q[sb+3], 32'hFFFF_FFFC);
      chk("wrap_src4", src_q[sb+4], 32'h0000_0000);
      chk("wrap_src24", src_q[sb+24], 32'h0000_0050);
    end
    chk("wrap_done", done_cnt - db, 1);

    chk("acc_addr_zero_when_idle", addr0_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ACC_BASE, 32'h1000_0000, accelerator base address.
- LOAD_WORDS, 25, words loaded per job (16 image + 9 kernel).
- RES_OFFSET, 32'h0000_0064, result window offset from ACC_BASE.
- RD_BEATS, 4, 64-bit result beats per job.
- WAIT_CYCLES, 10, compute wait after the last write, 1..255.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state is rising-edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle job request.
- src_base, in, 32: byte address of the first source word; sampled at accepted start.
- abort, in, 1: cancel the current job.
- src_en, out, 1: source memory read enable.
- src_addr, out, 32: source read address.
- src_rdata, in, 32: source data, valid exactly 1 cycle after src_en.
- acc_en_w, out, 1: accelerator write enable.
- acc_en_r, out, 1: accelerator read enable.
- acc_addr, out, 32: accelerator address.
- acc_wdata, out, 32: accelerator write data.
- acc_rdata, in, 64: accelerator read data, valid 1 cycle after acc_en_r.
- res_valid, out, 1: result beat valid.
- res_data, out, 64: result beat.
- res_ready, in, 1: consumer accepts the beat.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when a job completes.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, WAIT, RD_REQ, RD_CAP, OUT and DONE; encoding is free.
REQ-004 In IDLE, start=1 SHALL latch src_base, clear all counters and enter LOAD the next cycle; start in any other state SHALL be ignored.
REQ-005 In LOAD, word k (0..LOAD_WORDS-1) SHALL be fetched in cycle k with src_en=1 and src_addr=src_base+4k.
REQ-006 In cycle k+1 of LOAD, word k SHALL be written with acc_en_w=1, acc_addr=ACC_BASE+4k and acc_wdata=src_rdata (combinational pass-through); this is pipelined, one word per cycle.
REQ-007 LOAD SHALL last LOAD_WORDS+1 cycles (26 at default); src_en SHALL be low in its final cycle.
REQ-008 After the last write, the FSM SHALL enter WAIT and stay exactly WAIT_CYCLES cycles with all acc_* and src_* enables low.
REQ-009 In RD_REQ (1 cycle), the block SHALL drive acc_en_r=1 and acc_addr=ACC_BASE+RES_OFFSET+8b, where b is the beat index 0..RD_BEATS-1.
REQ-010 In RD_CAP (1 cycle), the block SHALL register acc_rdata into res_data and then enter OUT.
REQ-011 In OUT, res_valid SHALL be 1 and res_data SHALL be held stable until a cycle with res_ready=1.
REQ-012 On that res_ready cycle, b SHALL increment; the FSM SHALL go to RD_REQ if b<RD_BEATS-1, otherwise to DONE.
REQ-013 res_ready while res_valid=0 SHALL be ignored.
REQ-014 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-015 acc_addr SHALL be 0 whenever acc_en_w=0 and acc_en_r=0; acc_wdata is don't-care when acc_en_w=0.
REQ-016 Address arithmetic SHALL be 32-bit modulo 2^32; src_addr wrap-around past 32'hFFFF_FFFC is permitted and not flagged.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE the next cycle, deassert all enables and res_valid in that cycle, and suppress done.
REQ-018 abort SHALL have priority over start and res_ready.
REQ-019 abort in IDLE SHALL have no effect.
REQ-020 A start in the same cycle as DONE SHALL be ignored; a new job is accepted only from IDLE.

Reset
REQ-021 reset_n=0 SHALL immediately force IDLE and clear all counters, the latched src_base and res_data.
REQ-022 During reset, outputs SHALL be: src_en=0, src_addr=0, acc_en_w=0, acc_en_r=0, acc_addr=0, res_valid=0, busy=0, done=0.
REQ-023 Reset asserted mid-job SHALL abandon the job without a done pulse; the first start after reset_n deasserts SHALL begin a fresh job.

Verification
REQ-024 Basic job: src_base=0x100 with a source holding 1,2,3,4 x4 then 1,4,7,2,5,8,3,6,9 -> 25 writes, addresses 0x1000_0000..0x1000_0060, data in that order, on consecutive cycles.
REQ-025 Timing: start at cycle 0 -> first acc_en_w at cycle 2, last at cycle 26, first acc_en_r at cycle 37 (WAIT_CYCLES=10), read addresses 0x1000_0064/6C/74/7C.
REQ-026 Backpressure: res_ready held low 5 cycles on beat 1 -> res_data stable, no extra acc_en_r, all 4 beats delivered in order, single done.
REQ-027 Abort: abort during LOAD at word 7 -> next cycle busy=0 and all enables 0, no done; a following start reloads from word 0.
REQ-028 Busy start: start pulsed during WAIT and during DONE -> ignored; exactly one job runs.
REQ-029 Async reset: reset_n low mid-OUT for 3 cycles -> res_valid and busy drop without waiting for a clock edge; no done; the next job completes normally.
